// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared geometry defaults for the dpram RAM and its FIFO wrapper
package dpram_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

endpackage

// File: rtl/dpram.sv
// rtl/dpram.sv - 16x8 dual-port RAM, one write port and one registered read port
// Ports: clk; we/addr_wr/data_in write port; re/addr_rd read port; data_out registered read data.
module dpram #(
    parameter int DATA_W = dpram_pkg::DATA_W,
    parameter int ADDR_W = dpram_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr_wr,
    input  logic [ADDR_W-1:0] addr_rd,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // No reset on the array or the read register: contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr_wr] <= data_in;
        end
        if (re) begin
            data_out <= mem[addr_rd];
        end
    end

endmodule

// File: rtl/dpram_fifo.sv
// rtl/dpram_fifo.sv - synchronous push/pop FIFO wrapped around the dpram RAM
// Ports: clk, rst (sync, active-high); wr_en/wr_data push; rd_en pop, rd_data/rd_valid popped word;
//        full, almost_full, empty, count status; overflow/underflow one-cycle refusal pulses.
module dpram_fifo #(
    parameter int DATA_W   = dpram_pkg::DATA_W,
    parameter int ADDR_W   = dpram_pkg::ADDR_W,
    parameter int AF_LEVEL = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              almost_full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W + 1)'(AF_LEVEL);

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   cnt;
    logic              rv;
    logic              primed;
    logic              ovf;
    logic              udf;
    logic              wa;
    logic              ra;
    logic [DATA_W-1:0] ram_q;

    // Flags come only from the registered count, never from same-cycle requests.
    assign full        = (cnt == FULL_CNT);
    assign almost_full = (cnt >= AF_CNT);
    assign empty       = (cnt == '0);
    assign count       = cnt;

    assign wa = wr_en && !full;
    assign ra = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            cnt    <= '0;
            rv     <= 1'b0;
            primed <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wa) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (ra) begin
                rptr <= rptr + ADDR_W'(1);
            end
            case ({wa, ra})
                2'b10:   cnt <= cnt + (ADDR_W + 1)'(1);
                2'b01:   cnt <= cnt - (ADDR_W + 1)'(1);
                default: cnt <= cnt;
            endcase
            rv     <= ra;
            primed <= primed | rv;
            ovf    <= wr_en && full;
            udf    <= rd_en && empty;
        end
    end

    // The RAM read register is not reset, so the output is masked until the
    // first word has actually been popped; afterwards it holds the last pop.
    assign rd_data   = (primed || rv) ? ram_q : '0;
    assign rd_valid  = rv;
    assign overflow  = ovf;
    assign underflow = udf;

    // Pointers can never collide while both ports are active: a pop needs
    // count >= 1 and a push needs count <= DEPTH-1.
    dpram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (clk, wa, ra, wptr, rptr, wr_data, ram_q);

endmodule
